// File: rtl/fwd_operand_unit.sv
// fwd_operand_unit: operand forwarding and load-use / interlock hazard unit for a 5-stage pipeline.
// Ports: clock_i/reset_n_i (async active-low), hold_i freezes the tracker;
// id_* describe the instruction in ID; exmem_alu_out_i/memwb_value_i are the forwarding sources;
// stall_o holds PC and IF/ID; ex_* are the forwarded EX operands; fwd_*_sel_o report the operand source
// (00 reg, 01 MEM/WB, 10 EX/MEM, 11 immediate).
module fwd_operand_unit #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int FWD_EN = 1
) (
  input  logic            clock_i,
  input  logic            reset_n_i,
  input  logic            hold_i,
  input  logic            id_valid_i,
  input  logic [AW-1:0]   id_rs_i,
  input  logic [AW-1:0]   id_rt_i,
  input  logic            id_rs_use_i,
  input  logic            id_rt_use_i,
  input  logic [XLEN-1:0] id_rs_val_i,
  input  logic [XLEN-1:0] id_rt_val_i,
  input  logic [15:0]     id_imm16_i,
  input  logic            id_use_imm_i,
  input  logic            id_zext_i,
  input  logic [AW-1:0]   id_rd_i,
  input  logic            id_we_i,
  input  logic            id_is_load_i,
  input  logic [XLEN-1:0] exmem_alu_out_i,
  input  logic [XLEN-1:0] memwb_value_i,
  output logic            stall_o,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_a_o,
  output logic [XLEN-1:0] ex_b_o,
  output logic [XLEN-1:0] ex_store_data_o,
  output logic [1:0]      fwd_a_sel_o,
  output logic [1:0]      fwd_b_sel_o
);
  typedef struct packed {
    logic          v;
    logic          we;
    logic [AW-1:0] rd;
  } ent_t;
  ent_t            ex_q, ex_d, mem_q, wb_q;
  logic            ex_ld_q, ex_ld_d, use_imm_q, cap;
  logic [AW-1:0]   rs_q, rt_q;
  logic [XLEN-1:0] rs_val_q, rt_val_q, imm_q, imm_d;
  logic [1:0]      sel_rs, sel_rt;
  // Register 0 is hardwired, so a write to it never produces a value worth forwarding or waiting for.
  function automatic logic hit(input ent_t e, input logic [AW-1:0] r);
    return e.v && e.we && e.rd != '0 && e.rd == r;
  endfunction
  // With forwarding only a load still in EX is unresolvable; without it any pending writer blocks.
  function automatic logic hazard(input logic [AW-1:0] r);
    return FWD_EN != 0 ? hit(ex_q, r) && ex_ld_q : hit(ex_q, r) || hit(mem_q, r) || hit(wb_q, r);
  endfunction
  // MEM is checked before WB so the younger producer wins.
  function automatic logic [1:0] fsel(input logic [AW-1:0] r);
    return FWD_EN == 0 ? 2'b00 : hit(mem_q, r) ? 2'b10 : hit(wb_q, r) ? 2'b01 : 2'b00;
  endfunction
  function automatic logic [XLEN-1:0] fval(input logic [1:0] s, input logic [XLEN-1:0] v);
    return s == 2'b10 ? exmem_alu_out_i : s == 2'b01 ? memwb_value_i : v;
  endfunction
  assign stall_o = id_valid_i && ((id_rs_use_i && hazard(id_rs_i)) || (id_rt_use_i && hazard(id_rt_i)));
  assign cap     = id_valid_i && !stall_o;
  assign ex_d    = '{v: cap, we: cap && id_we_i, rd: id_rd_i};
  assign ex_ld_d = cap && id_is_load_i;
  assign imm_d   = {{(XLEN-16){!id_zext_i && id_imm16_i[15]}}, id_imm16_i};
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      ex_ld_q   <= 1'b0;
      use_imm_q <= 1'b0;
      rs_q      <= '0;
      rt_q      <= '0;
      rs_val_q  <= '0;
      rt_val_q  <= '0;
      imm_q     <= '0;
    end else if (!hold_i) begin
      wb_q    <= mem_q;
      mem_q   <= ex_q;
      ex_q    <= ex_d;
      ex_ld_q <= ex_ld_d;
      if (cap) begin
        rs_q      <= id_rs_i;
        rt_q      <= id_rt_i;
        rs_val_q  <= id_rs_val_i;
        rt_val_q  <= id_rt_val_i;
        imm_q     <= imm_d;
        use_imm_q <= id_use_imm_i;
      end
    end
  end
  assign sel_rs          = fsel(rs_q);
  assign sel_rt          = fsel(rt_q);
  assign ex_valid_o      = ex_q.v;
  assign fwd_a_sel_o     = sel_rs;
  assign ex_a_o          = fval(sel_rs, rs_val_q);
  assign ex_store_data_o = fval(sel_rt, rt_val_q);
  assign fwd_b_sel_o     = use_imm_q ? 2'b11 : sel_rt;
  assign ex_b_o          = use_imm_q ? imm_q : ex_store_data_o;
endmodule

// File: doc/fwd_operand_unit.md
FWD_OPERAND_UNIT -- requirements
Module: fwd_operand_unit

Interface
REQ-001 Parameter XLEN, default 32: datapath width in bits (16..64).
REQ-002 Parameter AW, default 5: register-address width.
REQ-003 Parameter FWD_EN, default 1: 1 = forward from EX/MEM and MEM/WB; 0 = interlock only, no forwarding.
REQ-004 Ports, one clock; reset is asynchronous and active-low:
  clock  in  1  rising-edge clock
  reset_n  in  1  asynchronous active-low reset
  hold  in  1  global pipeline freeze (memory wait)
  id_valid  in  1  instruction present in ID
  id_rs, id_rt  in  AW each  source register numbers
  id_rs_use, id_rt_use  in  1 each  source actually read
  id_rs_val, id_rt_val  in  XLEN each  register-file read data
  id_imm16  in  16  immediate field
  id_use_imm  in  1  operand B is the immediate (ADD_IMM/LW/SW class)
  id_zext  in  1  zero-extend immediate (logical-immediate class) instead of sign-extend
  id_rd  in  AW  destination register
  id_we  in  1  instruction writes rd
  id_is_load  in  1  instruction is LW
  exmem_alu_out  in  XLEN  result held in EX/MEM
  memwb_value  in  XLEN  write-back value in MEM/WB
  stall  out  1  hold PC and IF/ID this cycle
  ex_valid  out  1  EX stage holds a real instruction
  ex_a, ex_b  out  XLEN each  forwarded ALU operands
  ex_store_data  out  XLEN  forwarded rt for SW
  fwd_a_sel, fwd_b_sel  out  2 each  00 reg, 01 MEM/WB, 10 EX/MEM, 11 immediate (B only)

Function
REQ-005 Internal tracker: three entries EX, MEM, WB, each {valid, rd, we, is_load}; EX entry also holds rs, rt, rs_val, rt_val, extended immediate, use_imm.
REQ-006 When hold=0, on each clock edge: WB<=MEM, MEM<=EX, EX<=ID capture when id_valid=1 and stall=0, else EX<=bubble (valid=0, we=0).
REQ-007 When hold=1, all entries keep their values; stall is still computed but not acted on.
REQ-008 Extended immediate: id_zext=1 gives {zeros, imm16}, otherwise {XLEN-16 copies of imm16[15], imm16}; extension is done at capture.
REQ-009 Match(entry, r) is true when the entry has valid=1, we=1, rd!=0 and rd==r; register 0 is never forwarded and never stalls.
REQ-010 In FWD_EN=1, for each EX source r the priority is:
  - MEM match -> exmem_alu_out, sel 10;
  - else WB match -> memwb_value, sel 01;
  - else the captured value, sel 00.
REQ-011 ex_b = extended immediate with fwd_b_sel=11 when use_imm=1; otherwise ex_b follows REQ-010 for rt.
REQ-012 ex_store_data always follows REQ-010 for rt, independent of use_imm.
REQ-013 In FWD_EN=1, stall=1 iff id_valid=1 and a used ID source matches the EX entry with is_load=1 (load-use); this stall lasts exactly one cycle per hazard.
REQ-014 In FWD_EN=0, stall=1 iff id_valid=1 and a used ID source matches the EX, MEM or WB entry; all selects stay 00 (11 for immediate).
REQ-015 ex_a, ex_b, ex_store_data and the selects are combinational from tracker state and the exmem/memwb inputs; stall is combinational from ID inputs and tracker state.
REQ-016 If both rs and rt hazard, a single stall is raised; a source with *_use=0 never causes a hazard.
REQ-017 If an ID source matches both MEM and WB, the MEM (younger) value wins.
REQ-018 A bubble inserted by stall shall never match or forward.

Reset
REQ-019 reset_n=0 clears all entry valid/we bits immediately, independent of clock.
REQ-020 During reset: stall=0, ex_valid=0, ex_a=ex_b=ex_store_data=0, fwd_a_sel=fwd_b_sel=00.
REQ-021 Reset asserted mid-stall cancels the stall; the first edge after release captures ID normally.

Verification
REQ-022 ALU->ALU: write r3, then read r3 as rs next cycle, exmem_alu_out=0x0000_1234 -> ex_a=0x1234, fwd_a_sel=10, stall never set.
REQ-023 Load-use: LW r5, then ADD reading r5 -> stall=1 for one cycle and EX bubble (ex_valid=0); ADD then reaches EX with fwd from WB, memwb_value=0xDEAD_BEEF -> ex_a=0xDEADBEEF, fwd_a_sel=01.
REQ-024 Double match: r7 in MEM (0x11) and WB (0x22) -> ex_a=0x11; r0 as destination with reg read value 0 -> ex_a=0, sel 00.
REQ-025 Immediate: imm16=0x8001, use_imm=1 -> ex_b=0xFFFF_8001 with zext=0 and 0x0000_8001 with zext=1; ex_store_data still forwarded per rt.
REQ-026 FWD_EN=0: back-to-back dependent pair -> stall asserted 3 consecutive cycles, then ex_a = register value.
REQ-027 hold=1 for 4 cycles mid-hazard -> tracker frozen, outputs stable; reset_n pulse during a stall -> all outputs 0 at once.
